// File: rtl/lectura_fecha.sv
// lectura_fecha: reads the RTC date, month, year and day-of-week registers and publishes them together
module lectura_fecha #(
   parameter logic [7:0] ADDR_DATE = 8'h24,
   parameter logic [7:0] ADDR_MES  = 8'h25,
   parameter logic [7:0] ADDR_YEAR = 8'h26,
   parameter logic [7:0] ADDR_DAY  = 8'h27,
   parameter int         WAIT_CYC  = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] rd_data,
   output logic [7:0] direc,
   output logic       rd,
   output logic       busy,
   output logic       done,
   output logic       bcd_err,
   output logic [7:0] date,
   output logic [7:0] mes,
   output logic [7:0] year,
   output logic [7:0] day
);
   typedef enum logic [1:0] {IDLE, ADDR, STROBE, DONE} state_t;
   state_t state, state_n;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic [7:0] sh [4];
   logic [7:0] cap [4];
   logic [7:0] addr;
   logic       any_bad;
   // bus address of the field currently being read
   assign addr = idx == 2'd0 ? ADDR_DATE : idx == 2'd1 ? ADDR_MES : idx == 2'd2 ? ADDR_YEAR : ADDR_DAY;
   // state register; reset aborts any sequence at once
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_n;
   // next state and bus/handshake outputs, all decoded from the current state
   always_comb begin
      state_n = state;
      direc = 8'h00;
      rd = 1'b0;
      busy = 1'b0;
      done = 1'b0;
      case (state)
         IDLE: state_n = start ? ADDR : IDLE;
         ADDR: begin
            direc = addr;
            busy = 1'b1;
            state_n = STROBE;
         end
         STROBE: begin
            direc = addr;
            rd = 1'b1;
            busy = 1'b1;
            if (cnt == 4'd0) state_n = idx == 2'd3 ? DONE : ADDR;
         end
         default: begin
            done = 1'b1;
            state_n = IDLE;
         end
      endcase
   end
   // the byte being captured this cycle merged with the earlier shadows, so publication needs no extra cycle
   always_comb begin
      any_bad = 1'b0;
      for (int k = 0; k < 4; k++) begin
         cap[k] = idx == 2'(k) ? rd_data : sh[k];
         any_bad = any_bad | (cap[k][7:4] > 4'd9) | (cap[k][3:0] > 4'd9);
      end
   end
   // field index, strobe counter, shadow capture and atomic publication on entry to DONE
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         idx <= 2'd0;
         cnt <= 4'd0;
         for (int k = 0; k < 4; k++) sh[k] <= 8'h00;
         {date, mes, year, day, bcd_err} <= '0;
      end else begin
         if (state == IDLE && start) idx <= 2'd0;
         if (state == ADDR) cnt <= 4'(WAIT_CYC - 1);
         if (state == STROBE && cnt != 4'd0) cnt <= cnt - 4'd1;
         if (state == STROBE && cnt == 4'd0) begin
            sh[idx] <= rd_data;
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
               date <= cap[0];
               mes <= cap[1];
               year <= cap[2];
               day <= cap[3];
               bcd_err <= any_bad;
            end
         end
      end
endmodule

// File: tb/tb_lectura_fecha.sv
// tb_lectura_fecha: randomized self-checking bench with a cycle-timeline reference model
module tb_lectura_fecha;
   localparam int WAIT_CYC = 4;
   localparam int P = 1 + WAIT_CYC;
   localparam int DONE_C = 1 + 4 * P;
   logic clk = 1'b0, reset = 1'b1, start = 1'b0;
   logic [7:0] rd_data = 8'h00;
   logic [7:0] direc, date, mes, year, day;
   logic rd, busy, done, bcd_err;
   logic [7:0] mem [4];
   int n_cmp = 0, n_bad = 0;

   lectura_fecha #(.WAIT_CYC(WAIT_CYC)) dut (
      .clk(clk), .reset(reset), .start(start), .rd_data(rd_data), .direc(direc), .rd(rd),
      .busy(busy), .done(done), .bcd_err(bcd_err), .date(date), .mes(mes), .year(year), .day(day)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit bad_bcd(input logic [7:0] b);
      return (b / 16 > 9) || (b % 16 > 9);
   endfunction

   function automatic logic [7:0] bcd_or_junk();
      logic [7:0] v;
      v = 8'(($urandom_range(0, 9) << 4) + $urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) v = 8'($urandom);
      return v;
   endfunction

   // rd_data follows the addressed register; glitch overrides the early date strobe cycles
   task automatic drive_bus(input bit glitch, input int c);
      rd_data = (direc >= 8'h24 && direc <= 8'h27) ? mem[direc[1:0]] : 8'hEE;
      if (glitch && c >= 1 && c <= P && (c - 1) % P inside {[1:WAIT_CYC-1]}) rd_data = 8'hAA;
   endtask

   // expected bus/handshake behaviour at cycle c after start was sampled
   task automatic check_cycle(input int c);
      int k, p;
      k = (c - 1) / P;
      p = (c - 1) % P;
      if (c < DONE_C) begin
         chk("direc", direc, 8'(8'h24 + k));
         chk("rd", 8'(rd), 8'(p != 0));
         chk("busy", 8'(busy), 8'd1);
         chk("done_early", 8'(done), 8'd0);
      end else if (c == DONE_C) begin
         chk("done", 8'(done), 8'd1);
         chk("busy_done", 8'(busy), 8'd0);
         chk("rd_done", 8'(rd), 8'd0);
         chk("direc_done", direc, 8'd0);
         chk("date", date, mem[0]);
         chk("mes", mes, mem[1]);
         chk("year", year, mem[2]);
         chk("day", day, mem[3]);
         chk("bcd_err", 8'(bcd_err), 8'(bad_bcd(mem[0]) | bad_bcd(mem[1]) | bad_bcd(mem[2]) | bad_bcd(mem[3])));
      end else begin
         chk("done_after", 8'(done), 8'd0);
         chk("busy_after", 8'(busy), 8'd0);
         chk("date_held", date, mem[0]);
      end
   endtask

   task automatic run_seq(input bit glitch, input bit hold, input bit repulse);
      @(negedge clk);
      start = 1'b1;
      drive_bus(glitch, 0);
      for (int c = 1; c <= DONE_C + 1; c++) begin
         @(negedge clk);
         check_cycle(c);
         start = hold || (repulse && (c == 5 || c == DONE_C));
         drive_bus(glitch, c);
      end
      @(negedge clk);
      if (hold) begin
         chk("restart_direc", direc, 8'h24);
         chk("restart_busy", 8'(busy), 8'd1);
         start = 1'b0;
         begin
            int n = 0;
            while (!done && n < 40) begin
               drive_bus(1'b0, 0);
               @(negedge clk);
               n++;
            end
            chk("restart_done", 8'(done), 8'd1);
            chk("restart_date", date, mem[0]);
         end
      end else begin
         chk("no_restart_busy", 8'(busy), 8'd0);
         chk("no_restart_direc", direc, 8'd0);
      end
      start = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_busy", 8'(busy), 8'd0);
         chk("idle_rd", 8'(rd), 8'd0);
      end
      chk("idle_direc", direc, 8'd0);
      chk("idle_fields", date | mes | year | day, 8'd0);
      chk("idle_err", 8'(bcd_err), 8'd0);
      mem[0] = 8'h15; mem[1] = 8'h07; mem[2] = 8'h24; mem[3] = 8'h03;
      run_seq(1'b0, 1'b0, 1'b0);
      mem[0] = 8'h12;
      run_seq(1'b1, 1'b0, 1'b0);
      mem[0] = 8'h31; mem[1] = 8'h1A; mem[2] = 8'h99; mem[3] = 8'h06;
      run_seq(1'b0, 1'b0, 1'b0);
      mem[1] = 8'h12;
      run_seq(1'b0, 1'b0, 1'b1);
      mem[0] = 8'h28; mem[3] = 8'h05;
      run_seq(1'b0, 1'b1, 1'b0);
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < 4; i++) mem[i] = bcd_or_junk();
         run_seq(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      mem[0] = 8'h19; mem[1] = 8'h11; mem[2] = 8'h30; mem[3] = 8'h02;
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start = 1'b0;
         drive_bus(1'b0, c);
      end
      #1 reset = 1'b1;
      #1;
      chk("rst_rd_async", 8'(rd), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_fields", date | mes | year | day, 8'd0);
      chk("rst_err", 8'(bcd_err), 8'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("rst_no_done", 8'(done), 8'd0);
         chk("rst_idle", 8'(busy), 8'd0);
      end
      run_seq(1'b0, 1'b0, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
